// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: accepts a length-prefixed, XOR-checksummed byte
// frame, writes 16-bit words to imem and releases the datapath reset once verified.
module imem_boot_loader #(
   parameter int unsigned          ADDR_W    = 16,
   parameter int unsigned          ADDR_STEP = 2,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
   parameter int unsigned          MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reload,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error
);

   localparam int unsigned LEN_W = 16;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

   typedef enum logic [2:0] {
      S_LEN_HI, S_LEN_LO, S_LEN_VAL, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              rx_ready_d, imem_we_d, cpu_reset_d, load_done_d, load_error_d;
   logic [ADDR_W-1:0] imem_addr_d;
   logic [15:0]       imem_wdata_d;
   logic              accept;
   logic              restart;
   logic [LEN_W-1:0]  count_inc;

   assign accept    = rx_valid & rx_ready;
   assign restart   = reload & ((state_q == S_DONE) | (state_q == S_ERR));
   assign count_inc = LEN_W'(count_q + LEN_W'(1));

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      count_d      = count_q;
      hi_d         = hi_q;
      csum_d       = csum_q;
      waddr_d      = waddr_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr;
      imem_wdata_d = imem_wdata;

      case (state_q)
         S_LEN_HI: if (accept) begin
            len_d[15:8] = rx_data;
            csum_d      = csum_q ^ rx_data;
            state_d     = S_LEN_LO;
         end
         S_LEN_LO: if (accept) begin
            len_d[7:0] = rx_data;
            csum_d     = csum_q ^ rx_data;
            state_d    = S_LEN_VAL;
         end
         S_LEN_VAL: begin
            if (len_q == '0 || len_q > MAX_LEN) state_d = S_ERR;
            else                                state_d = S_DATA_HI;
         end
         S_DATA_HI: if (accept) begin
            hi_d    = rx_data;
            csum_d  = csum_q ^ rx_data;
            state_d = S_DATA_LO;
         end
         S_DATA_LO: if (accept) begin
            csum_d       = csum_q ^ rx_data;
            imem_we_d    = 1'b1;
            imem_wdata_d = {hi_q, rx_data};
            imem_addr_d  = waddr_q;
            waddr_d      = ADDR_W'(waddr_q + STEP);
            count_d      = count_inc;
            state_d      = (count_inc == len_q) ? S_CHECK : S_DATA_HI;
         end
         S_CHECK: if (accept) begin
            state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: if (reload) begin
            state_d     = S_LEN_HI;
            count_d     = '0;
            csum_d      = '0;
            waddr_d     = BASE_ADDR;
            imem_addr_d = BASE_ADDR;
         end
         default: state_d = S_LEN_HI;
      endcase

      rx_ready_d   = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                     (state_d == S_CHECK);
      // Status flags follow the state one cycle after entry; reload clears them at once
      load_done_d  = (state_q == S_DONE) && !restart;
      load_error_d = (state_q == S_ERR) && !restart;
      cpu_reset_d  = !load_done_d;
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_LEN_HI;
         len_q      <= '0;
         count_q    <= '0;
         hi_q       <= '0;
         csum_q     <= '0;
         waddr_q    <= BASE_ADDR;
         rx_ready   <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         count_q    <= count_d;
         hi_q       <= hi_d;
         csum_q     <= csum_d;
         waddr_q    <= waddr_d;
         rx_ready   <= rx_ready_d;
         imem_we    <= imem_we_d;
         imem_addr  <= imem_addr_d;
         imem_wdata <= imem_wdata_d;
         cpu_reset  <= cpu_reset_d;
         load_done  <= load_done_d;
         load_error <= load_error_d;
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal, bad checksum, illegal lengths,
// stalled stream, reload and asynchronous reset mid-load.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        reload;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [15:0] imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] wr_q[$];

   imem_boot_loader dut (
      .clk        (clk),
      .reset      (reset),
      .reload     (reload),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   // Log every write strobe as {addr, data}
   always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] csum, input int gap);
      logic [7:0] fr [6];
      fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      foreach (fr[i]) send_byte(fr[i], gap);
      send_byte(csum, gap);
   endtask

   task automatic pulse_reload();
      @(negedge clk); reload = 1'b1;
      @(negedge clk); reload = 1'b0;
   endtask

   task automatic check_nominal_writes(input string tag);
      check({tag, "_nwr"}, 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         check({tag, "_wr0"}, wr_q[0], 32'h0000_1234);
         check({tag, "_wr1"}, wr_q[1], 32'h0002_ABCD);
      end
   endtask

   initial begin
      reset = 1'b1; reload = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (2) @(negedge clk);
      check("rst_rx_ready",  32'(rx_ready),   32'd1);
      check("rst_we",        32'(imem_we),    32'd0);
      check("rst_addr",      32'(imem_addr),  32'd0);
      check("rst_wdata",     32'(imem_wdata), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset),  32'd1);
      check("rst_done",      32'(load_done),  32'd0);
      check("rst_error",     32'(load_error), 32'd0);
      reset = 1'b0;

      // Nominal load with checksum 0x42; release one edge after the checksum accept
      wr_q.delete();
      send_frame(8'h42, 0);
      @(negedge clk);
      check("nom_cpu_reset_k", 32'(cpu_reset), 32'd1);
      @(negedge clk);
      check("nom_cpu_reset",   32'(cpu_reset), 32'd0);
      check("nom_done",        32'(load_done), 32'd1);
      check("nom_error",       32'(load_error), 32'd0);
      check("nom_rx_ready",    32'(rx_ready),  32'd0);
      check_nominal_writes("nom");

      // Bad checksum
      pulse_reload();
      check("rl_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rl_done",      32'(load_done), 32'd0);
      wr_q.delete();
      send_frame(8'h43, 0);
      repeat (3) @(negedge clk);
      check("bad_error",     32'(load_error), 32'd1);
      check("bad_cpu_reset", 32'(cpu_reset),  32'd1);
      check("bad_done",      32'(load_done),  32'd0);
      check("bad_rx_ready",  32'(rx_ready),   32'd0);
      check_nominal_writes("bad");

      // Zero length
      pulse_reload();
      check("rl_err_clear", 32'(load_error), 32'd0);
      check("rl_addr",      32'(imem_addr),  32'd0);
      wr_q.delete();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      repeat (4) @(negedge clk);
      check("len0_error", 32'(load_error), 32'd1);
      check("len0_nwr",   32'(wr_q.size()), 32'd0);

      // Length 257 exceeds the limit
      pulse_reload();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      repeat (4) @(negedge clk);
      check("len257_error",     32'(load_error), 32'd1);
      check("len257_cpu_reset", 32'(cpu_reset),  32'd1);
      check("len257_nwr",       32'(wr_q.size()), 32'd0);

      // Stalled stream after reload from ERR; a mid-load reload must be ignored
      pulse_reload();
      wr_q.delete();
      send_byte(8'h00, 3);
      send_byte(8'h02, 3);
      send_byte(8'h12, 3);
      pulse_reload();
      send_byte(8'h34, 3);
      send_byte(8'hAB, 3);
      send_byte(8'hCD, 3);
      send_byte(8'h42, 3);
      repeat (5) @(negedge clk);
      check("stall_done",      32'(load_done), 32'd1);
      check("stall_cpu_reset", 32'(cpu_reset), 32'd0);
      check("stall_error",     32'(load_error), 32'd0);
      check_nominal_writes("stall");

      // Async reset mid-load, checked before the next clock edge
      pulse_reload();
      wr_q.delete();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'hAB, 0);
      @(negedge clk);
      check("pre_rst_wdata", 32'(imem_wdata), 32'h1234);
      #2 reset = 1'b1;
      #1;
      check("arst_wdata",     32'(imem_wdata), 32'd0);
      check("arst_addr",      32'(imem_addr),  32'd0);
      check("arst_rx_ready",  32'(rx_ready),   32'd1);
      check("arst_we",        32'(imem_we),    32'd0);
      check("arst_cpu_reset", 32'(cpu_reset),  32'd1);
      @(negedge clk);
      reset = 1'b0;
      wr_q.delete();
      send_frame(8'h42, 0);
      repeat (2) @(negedge clk);
      check("post_rst_done",      32'(load_done), 32'd1);
      check("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);
      check_nominal_writes("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Writer side of the 16-bit MIPS datapath's instruction memory: receives a program as a byte stream over a valid/ready handshake and writes it word-by-word into instruction memory.
- Holds the datapath in reset until a complete, checksum-verified image is loaded, then releases it.
- Sits between the host/UART byte receiver and the instruction-memory write port; drives the datapath's reset input.

Parameters:
- ADDR_W, 16, width of instruction-memory address (matches 16-bit PC).
- ADDR_STEP, 2, address increment per 16-bit word (byte-addressed PC, PC+2 per instruction).
- BASE_ADDR, 16'h0000, address of first loaded word.
- MAX_WORDS, 256, largest legal word count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reload  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  write data.
- cpu_reset  out  1  active-high reset to datapath.
- load_done  out  1  image loaded and verified.
- load_error  out  1  length or checksum failure.

Behaviour:
- Reset (async): state=LEN_HI, rx_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, count=0, csum=0.
- Byte accepted only when rx_valid && rx_ready, on rising clk. rx_ready is registered: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK; 0 in LEN_VAL, DONE, ERR.
- Frame: LEN_HI, LEN_LO (big-endian word count N), then N words as hi byte then lo byte, then one checksum byte.
- Checksum: XOR of every accepted byte except the checksum byte itself, including both length bytes.
- FSM:
  - LEN_HI -> LEN_LO on accept; stores length[15:8].
  - LEN_LO -> LEN_VAL on accept; stores length[7:0].
  - LEN_VAL (one cycle, no accept): N==0 or N>MAX_WORDS -> ERR; otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO on accept; stores hi byte.
  - DATA_LO on accept: next cycle imem_we=1, imem_wdata={hi,lo}, imem_addr=current word address; count+=1. Goes to CHECK if count reaches N, else DATA_HI.
  - Word address = BASE_ADDR + index*ADDR_STEP, modulo 2^ADDR_W; wrap-around is silent.
  - CHECK on accept: byte==csum -> DONE, else -> ERR.
  - DONE: cpu_reset=0 and load_done=1, both registered, first asserted in the cycle after entry.
  - ERR: load_error=1, cpu_reset stays 1.
- imem_we is a one-cycle pulse per word. imem_addr/imem_wdata hold their last values when imem_we=0.
- Words are written before verification. On ERR, memory content is undefined, and the CPU is never released.
- reload in DONE or ERR: next cycle state=LEN_HI, cpu_reset=1, load_done=0, load_error=0, count=0, csum=0, imem_addr=BASE_ADDR. reload is ignored in all other states.
- Gaps: rx_valid low for any number of cycles stalls the FSM with no state change.
- Reset asserted mid-load aborts immediately to reset values; partial memory writes are not undone.
- Latency: last checksum byte accepted at edge k -> cpu_reset low after edge k+1.

Test Plan:
- Nominal load: bytes 00 02 12 34 AB CD, csum=00^02^12^34^AB^CD=0x42 → writes (0x0000,0x1234), (0x0002,0xABCD); cpu_reset=0 and load_done=1 one cycle after csum accept.
- Bad checksum: same frame with csum 0x43 → 2 writes occur, load_error=1, cpu_reset stays 1, rx_ready=0.
- Illegal length: 00 00 → ERR with no writes. Separately, 01 01 (257 > MAX_WORDS) → ERR with no writes.
- Stalled stream: nominal frame with rx_valid low for 3 cycles between every byte → identical writes and result; no extra imem_we pulses.
- Reload: after ERR, pulse reload then send the nominal frame → errors clear; writes restart at 0x0000; load_done=1.
- Async reset mid-load: assert reset after the first data byte → all outputs return to reset values immediately; a following nominal frame loads correctly.
